// File: rtl/aec_result_fmt.sv
// Result formatter: FIFO of {legal, result} drained as ASCII lines on a valid/ready byte stream.
// First char valid one edge after the push; a stall holds out_char; full FIFO drops (sticky overflow); AEC_FMT_DEC_EN selects decimal.

module aec_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_dat,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head_dat,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  assign head_dat = mem[rd_ptr];
  assign full     = (count == FULL_CNT);
  assign empty    = (count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Caller only pushes into a full FIFO when it pops in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module aec_result_fmt #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   valid,
  input  logic [6:0]             result,
  input  logic                   parenthesesLegal,
  output logic                   out_valid,
  output logic [7:0]             out_char,
  input  logic                   out_ready,
  output logic                   busy,
  output logic                   overflow,
  output logic [$clog2(DEPTH):0] fifo_count
);
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

`ifdef AEC_FMT_DEC_EN
  localparam logic [1:0] LEGAL_LAST = 2'd3;
`else
  localparam logic [1:0] LEGAL_LAST = 2'd2;
`endif
  localparam logic [1:0] ERR_LAST = 2'd3;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_E     = 8'h45;
  localparam logic [7:0] CH_R     = 8'h52;

  state_t      state;
  state_t      state_nxt;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;
  logic        cur_legal;
  logic [1:0]  idx;
  logic        at_last;
  logic        xfer;
  logic [7:0]  line_char;
`ifdef AEC_FMT_DEC_EN
  logic [11:0] cur_bcd;

  function automatic logic [11:0] to_bcd(input logic [6:0] v);
    logic [6:0] h;
    logic [6:0] t;
    logic [6:0] o;
    h = v / 7'd100;
    t = (v / 7'd10) % 7'd10;
    o = v % 7'd10;
    return {h[3:0], t[3:0], o[3:0]};
  endfunction

  function automatic logic [7:0] dec_char(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction
`else
  logic [6:0]  cur_val;

  function automatic logic [7:0] hex_char(input logic [3:0] d);
    return (d < 4'd10) ? (8'h30 + {4'h0, d}) : (8'h57 + {4'h0, d});
  endfunction
`endif

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign fifo_push = valid && (!fifo_full || fifo_pop);

  aec_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (fifo_push),
    .push_dat ({parenthesesLegal, result}),
    .pop      (fifo_pop),
    .head_dat (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign busy    = (state != IDLE) || !fifo_empty;
  assign xfer    = (state == SEND) && out_ready;
  assign at_last = (idx == (cur_legal ? LEGAL_LAST : ERR_LAST));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
    end else if (valid && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = SEND;
      SEND:    if (out_ready && at_last && fifo_empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    out_valid = 1'b0;
    out_char  = 8'h00;
    fifo_pop  = 1'b0;
    case (state)
      IDLE: fifo_pop = !fifo_empty;
      SEND: begin
        out_valid = 1'b1;
        out_char  = line_char;
        fifo_pop  = out_ready && at_last && !fifo_empty;
      end
      default: fifo_pop = 1'b0;
    endcase
  end

  always_comb begin
    line_char = CH_LF;
    if (!cur_legal) begin
      case (idx)
        2'd0:       line_char = CH_E;
        2'd1, 2'd2: line_char = CH_R;
        default:    line_char = CH_LF;
      endcase
    end else begin
`ifdef AEC_FMT_DEC_EN
      case (idx)
        2'd0:    line_char = dec_char(cur_bcd[11:8]);
        2'd1:    line_char = dec_char(cur_bcd[7:4]);
        2'd2:    line_char = dec_char(cur_bcd[3:0]);
        default: line_char = CH_LF;
      endcase
`else
      case (idx)
        2'd0:    line_char = hex_char({1'b0, cur_val[6:4]});
        2'd1:    line_char = hex_char(cur_val[3:0]);
        default: line_char = CH_LF;
      endcase
`endif
    end
  end

  // Digits are latched at pop time so SEND starts on the first character.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_legal <= 1'b0;
      idx       <= 2'd0;
`ifdef AEC_FMT_DEC_EN
      cur_bcd   <= '0;
`else
      cur_val   <= '0;
`endif
    end else if (fifo_pop) begin
      cur_legal <= fifo_head[7];
      idx       <= 2'd0;
`ifdef AEC_FMT_DEC_EN
      cur_bcd   <= to_bcd(fifo_head[6:0]);
`else
      cur_val   <= fifo_head[6:0];
`endif
    end else if (xfer && !at_last) begin
      idx <= idx + 2'd1;
    end
  end
endmodule

// File: tb/tb_aec_result_fmt.sv
// Directed bench for aec_result_fmt: inputs driven and outputs sampled on the falling clock edge.
module tb_aec_result_fmt;
  localparam int DEPTH = 4;
`ifdef AEC_FMT_DEC_EN
  localparam int LEGAL_LEN = 4;
`else
  localparam int LEGAL_LEN = 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       valid = 1'b0;
  logic [6:0] result = '0;
  logic       parenthesesLegal = 1'b0;
  logic       out_valid;
  logic [7:0] out_char;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       overflow;
  logic [2:0] fifo_count;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  string      hex_digits = "0123456789abcdef";

  always #5 clk = ~clk;

  aec_result_fmt #(.DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .valid            (valid),
    .result           (result),
    .parenthesesLegal (parenthesesLegal),
    .out_valid        (out_valid),
    .out_char         (out_char),
    .out_ready        (out_ready),
    .busy             (busy),
    .overflow         (overflow),
    .fifo_count       (fifo_count)
  );

  task automatic append_line(input logic legal, input logic [6:0] v);
    int iv;
    iv = int'(v);
    if (!legal) begin
      exp_q.push_back(8'h45);
      exp_q.push_back(8'h52);
      exp_q.push_back(8'h52);
    end else begin
`ifdef AEC_FMT_DEC_EN
      exp_q.push_back(8'(48 + iv / 100));
      exp_q.push_back(8'(48 + (iv / 10) % 10));
      exp_q.push_back(8'(48 + iv % 10));
`else
      exp_q.push_back(hex_digits[iv / 16]);
      exp_q.push_back(hex_digits[iv % 16]);
`endif
    end
    exp_q.push_back(8'h0A);
  endtask

  task automatic apply_reset();
    valid = 1'b0;
    out_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic pulse(input logic legal, input logic [6:0] v);
    valid = 1'b1;
    result = v;
    parenthesesLegal = legal;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic drain(input logic [3:0] pat, input int max_cycles, output bit timed_out);
    timed_out = 1'b1;
    for (int n = 0; n < max_cycles; n++) begin
      if (!busy && !out_valid) begin
        timed_out = 1'b0;
        break;
      end
      out_ready = pat[n % 4];
      #1;
      if (out_valid && out_ready) rx_q.push_back(out_char);
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #3;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_char !== 8'h00) begin errors++; $display("FAIL rst_out_char: got %h expected 00", out_char); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", busy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow: got %b expected 0", overflow); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d expected 0", fifo_count); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rst_release: got busy=%b out_valid=%b expected 0 0", busy, out_valid); end
  endtask

  task automatic test_legal_line();
    logic [7:0] e [4];
`ifdef AEC_FMT_DEC_EN
    e = '{8'h30, 8'h34, 8'h32, 8'h0A};
`else
    e = '{8'h32, 8'h61, 8'h0A, 8'h00};
`endif
    out_ready = 1'b1;
    pulse(1'b1, 7'h2A);
    checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL legal_count: got %0d expected 1", fifo_count); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL legal_latency: got out_valid=%b expected 0", out_valid); end
    @(negedge clk);
    for (int i = 0; i < LEGAL_LEN; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_char !== e[i]) begin
        errors++;
        $display("FAIL legal_char[%0d]: got valid=%b char=%h expected valid=1 char=%h", i, out_valid, out_char, e[i]);
      end
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL legal_idle: got out_valid=%b busy=%b expected 0 0", out_valid, busy); end
  endtask

  task automatic test_error_line();
    bit to;
    logic [7:0] e [4];
    e = '{8'h45, 8'h52, 8'h52, 8'h0A};
    rx_q.delete();
    pulse(1'b0, 7'h7F);
    drain(4'b1111, 100, to);
    checks++; if (to) begin errors++; $display("FAIL err_timeout: got busy=%b expected idle", busy); end
    checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL err_len: got %0d chars expected 4", rx_q.size()); end
    for (int i = 0; i < 4 && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== e[i]) begin errors++; $display("FAIL err_char[%0d]: got %h expected %h", i, rx_q[i], e[i]); end
    end
  endtask

  task automatic test_stall();
    bit         prev_stalled;
    logic [7:0] prev_char;
    bit         done;
    rx_q.delete();
    exp_q.delete();
    append_line(1'b1, 7'h5C);
    out_ready = 1'b0;
    pulse(1'b1, 7'h5C);
    prev_stalled = 1'b0;
    prev_char = 8'h00;
    done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if (!busy && !out_valid) begin
        done = 1'b1;
        break;
      end
      if (prev_stalled) begin
        checks++;
        if (out_valid !== 1'b1 || out_char !== prev_char) begin
          errors++;
          $display("FAIL stall_hold: got valid=%b char=%h expected valid=1 char=%h", out_valid, out_char, prev_char);
        end
      end
      out_ready = (n % 3 == 0);
      #1;
      if (out_valid && out_ready) rx_q.push_back(out_char);
      prev_stalled = out_valid && !out_ready;
      prev_char = out_char;
      @(negedge clk);
    end
    checks++; if (!done) begin errors++; $display("FAIL stall_timeout: got busy=%b expected idle", busy); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_char[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    bit to;
    apply_reset();
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 6; i++) begin
      pulse(1'b1, 7'(10 + i * 17));
      if (i < 5) append_line(1'b1, 7'(10 + i * 17));
    end
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
    checks++; if (out_valid !== 1'b1 || out_char !== exp_q[0]) begin errors++; $display("FAIL ovf_cur: got valid=%b char=%h expected valid=1 char=%h", out_valid, out_char, exp_q[0]); end
    drain(4'b1111, 200, to);
    checks++; if (to) begin errors++; $display("FAIL ovf_timeout: got busy=%b expected idle", busy); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL ovf_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL ovf_char[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  task automatic test_push_full_pop();
    bit to;
    logic [6:0] vals [6];
    vals = '{7'h01, 7'h12, 7'h23, 7'h34, 7'h45, 7'h56};
    apply_reset();
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 5; i++) pulse(1'b1, vals[i]);
    for (int i = 1; i < 6; i++) append_line(1'b1, vals[i]);
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", fifo_count); end
    out_ready = 1'b1;
    repeat (LEGAL_LEN - 1) @(negedge clk);
    checks++; if (out_char !== 8'h0A) begin errors++; $display("FAIL full_last: got %h expected 0a", out_char); end
    valid = 1'b1;
    result = vals[5];
    parenthesesLegal = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_swap_count: got %0d expected 4", fifo_count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_swap_ovf: got %b expected 0", overflow); end
    checks++; if (out_valid !== 1'b1 || out_char !== exp_q[0]) begin errors++; $display("FAIL full_no_bubble: got valid=%b char=%h expected valid=1 char=%h", out_valid, out_char, exp_q[0]); end
    drain(4'b1111, 200, to);
    checks++; if (to) begin errors++; $display("FAIL full_timeout: got busy=%b expected idle", busy); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL full_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL full_char[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid_line();
    bit to;
    apply_reset();
    pulse(1'b1, 7'h11);
    pulse(1'b1, 7'h22);
    out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_char !== 8'h31) begin errors++; $display("FAIL mid_second: got valid=%b char=%h expected valid=1 char=31", out_valid, out_char); end
    #2 rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid); end
    checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", fifo_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rx_q.delete();
    exp_q.delete();
    append_line(1'b1, 7'h07);
    pulse(1'b1, 7'h07);
    drain(4'b1111, 100, to);
    checks++; if (to) begin errors++; $display("FAIL mid_timeout: got busy=%b expected idle", busy); end
    checks++; if (rx_q.size() != exp_q.size()) begin errors++; $display("FAIL mid_len: got %0d expected %0d", rx_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++) begin
      checks++;
      if (rx_q[i] !== exp_q[i]) begin errors++; $display("FAIL mid_char[%0d]: got %h expected %h", i, rx_q[i], exp_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_legal_line();
    test_error_line();
    test_stall();
    test_overflow();
    test_push_full_pop();
    test_reset_mid_line();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion expected finish before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/aec_result_fmt.md
# aec_result_fmt

Downstream formatter for the arithmetic expression calculator. It captures each one-cycle `valid` pulse, together with `result` and `parenthesesLegal`, into a small result FIFO. It then serializes every entry as an ASCII line on a byte stream with a valid/ready handshake, so a console, UART or checker can consume the calculator's answers at its own pace.

## Interface
Parameters:
- `DEPTH`, default 4: result FIFO entries; must be a power of 2, minimum 2.

Ports:
- `clk`, input, 1: single clock; everything is rising-edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `valid`, input, 1: one-cycle pulse from the calculator; the result is present this cycle.
- `result`, input, 7: calculator result, unsigned, 0..127.
- `parenthesesLegal`, input, 1: 1 means the expression was legal; 0 means print an error.
- `out_valid`, output, 1: `out_char` holds a character to transfer.
- `out_char`, output, 8: ASCII character.
- `out_ready`, input, 1: sink accepts `out_char` in this cycle when `out_valid` is also 1.
- `busy`, output, 1: FSM is not IDLE, or the FIFO is non-empty.
- `overflow`, output, 1: sticky; set when a result is dropped.
- `fifo_count`, output, clog2(DEPTH)+1: number of FIFO entries.

## Operation
- **FIFO**
  - Each entry is 8 bits: {legal, result}.
  - `wr_ptr` and `rd_ptr` wrap modulo DEPTH.
  - Push occurs when `valid` = 1 and the FIFO is not full.
  - If the FIFO is full and no pop occurs in the same cycle, the entry is dropped and `overflow` is set.
  - Push and pop in the same cycle are both allowed, including when full; the count is unchanged.
- **FSM states:** IDLE, SEND.
  - IDLE: if the FIFO is non-empty, pop the head into `cur` (legal, value), set `idx` = 0 and go to SEND. Otherwise stay in IDLE.
  - SEND: `out_valid` = 1 and `out_char` = line[idx].
    - On `out_ready` = 1 with `idx` not at the last character: `idx` increments.
    - On `out_ready` = 1 at the last character: if the FIFO is non-empty, pop the next entry, set `idx` = 0 and stay in SEND (no bubble). Otherwise go to IDLE.
- **Line format**, default hex:
  - Legal entry, 3 characters: hex(value[6:4]), hex(value[3:0]), 0x0A.
  - Hex digits are 0x30–0x39 for 0–9 and lowercase 0x61–0x66 for a–f.
  - Illegal entry, 4 characters: 0x45, 0x52, 0x52, 0x0A ("ERR\n"). The value is ignored.
- **Handshake**
  - While `out_valid` = 1 and `out_ready` = 0, `out_char` and `out_valid` hold stable.
  - `out_valid` never drops without a transfer.
  - `out_ready` is ignored while `out_valid` = 0.
- **Overflow:** `overflow` clears only on reset.

## Timing
- **Reset values:**
  - `out_valid` = 0, `out_char` = 0x00, `busy` = 0, `overflow` = 0, `fifo_count` = 0.
  - Pointers are 0 and the FSM is in IDLE.
- **Reset mid-line:** the line is abandoned and FIFO contents are discarded. `out_valid` is low immediately, because reset is asynchronous.
- **Latency:**
  - `valid` sampled at edge N updates `fifo_count` after edge N.
  - If the FSM is IDLE, the first character has `out_valid` high after edge N+1.
  - With `out_ready` tied high, one character transfers per cycle, so a legal line takes 3 cycles.
- `fifo_count` and `busy` are registered-state outputs; they reflect state after each edge.
- **Back-to-back `valid` pulses** on consecutive cycles are each pushed, up to capacity.

## Configuration
- Macro `AEC_FMT_DEC_EN`.
  - **Defined:** a legal entry prints 3 zero-padded decimal digits plus 0x0A, 4 characters total. For example, 127 prints "127\n" and 5 prints "005\n".
    - Decimal digits come from iterative subtraction or a constant-divisor conversion done at pop time.
    - This adds no extra cycles: digits are ready when SEND is entered.
  - **Undefined:** hex format as above.
  - The error line is identical in both modes.

## Test plan
- Reset, then `valid` with `result` = 0x2A, legal = 1, and `out_ready` = 1 -> characters 0x32, 0x61, 0x0A on 3 consecutive cycles, with the first `out_valid` 2 edges after the pulse. With `AEC_FMT_DEC_EN` defined -> "042\n".
- `valid` with legal = 0 and `result` = 0x7F -> "ERR\n" (0x45, 0x52, 0x52, 0x0A); the value is ignored.
- `out_ready` toggling 1,0,0,1,… during a line -> `out_char` stays stable while stalled, with no lost or duplicated characters.
- DEPTH = 4 with `out_ready` = 0 and 6 `valid` pulses -> `fifo_count` = 4, one entry held in `cur`, one dropped, `overflow` = 1. Releasing `out_ready` then yields 5 lines in order.
- Push while full in the same cycle as a last-character pop -> the entry is accepted, `fifo_count` is unchanged, `overflow` stays 0, and the next line follows with no idle cycle.
- Drive `rst` low during the second character of a line -> `out_valid` = 0 and `fifo_count` = 0 immediately; after release, a new `valid` prints normally.
